// File: rtl/instr_pkg.sv
// Shared instruction-format definitions: format codes, encoder FSM states,
// immediate range limits and the captured request bundle.
package instr_pkg;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_ISH = 3'd2,
    FMT_S   = 3'd3,
    FMT_B   = 3'd4,
    FMT_U   = 3'd5,
    FMT_J   = 3'd6,
    FMT_RSV = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ENC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  // Signed limits of each immediate field (B/J are byte offsets, even only)
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMMB_MIN  = -4096;
  localparam int IMMB_MAX  = 4094;
  localparam int IMMJ_MIN  = -1048576;
  localparam int IMMJ_MAX  = 1048574;
  localparam int SHAMT_MIN = 0;
  localparam int SHAMT_MAX = 31;

  typedef struct packed {
    fmt_e        fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } req_t;

endpackage

// File: rtl/instr_pack.sv
// Pure combinational range check and bit packing of one request into a
// 32-bit instruction word; a rejected request yields an all-zero word.
module instr_pack
  import instr_pkg::*;
(
  input  req_t        i_req,
  output logic [31:0] o_instr,
  output logic        o_err
);

  logic signed [31:0] w_imm;
  logic [31:0]        w_raw;
  logic               w_bad;

  assign w_imm = i_req.imm;

  // Per-format field placement and representability check
  always_comb begin
    w_raw = 32'h0;
    w_bad = 1'b0;
    case (i_req.fmt)
      FMT_R: begin
        w_raw = {i_req.funct7, i_req.rs2, i_req.rs1, i_req.funct3, i_req.rd, i_req.opcode};
      end
      FMT_I: begin
        w_bad = (w_imm < IMM12_MIN) || (w_imm > IMM12_MAX);
        w_raw = {w_imm[11:0], i_req.rs1, i_req.funct3, i_req.rd, i_req.opcode};
      end
      FMT_ISH: begin
        w_bad = (w_imm < SHAMT_MIN) || (w_imm > SHAMT_MAX);
        w_raw = {i_req.funct7, w_imm[4:0], i_req.rs1, i_req.funct3, i_req.rd, i_req.opcode};
      end
      FMT_S: begin
        w_bad = (w_imm < IMM12_MIN) || (w_imm > IMM12_MAX);
        w_raw = {w_imm[11:5], i_req.rs2, i_req.rs1, i_req.funct3, w_imm[4:0], i_req.opcode};
      end
      FMT_B: begin
        w_bad = (w_imm < IMMB_MIN) || (w_imm > IMMB_MAX) || w_imm[0];
        w_raw = {w_imm[12], w_imm[10:5], i_req.rs2, i_req.rs1, i_req.funct3,
                 w_imm[4:1], w_imm[11], i_req.opcode};
      end
      FMT_U: begin
        w_bad = (w_imm[11:0] != 12'h0);
        w_raw = {w_imm[31:12], i_req.rd, i_req.opcode};
      end
      FMT_J: begin
        w_bad = (w_imm < IMMJ_MIN) || (w_imm > IMMJ_MAX) || w_imm[0];
        w_raw = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], i_req.rd, i_req.opcode};
      end
      default: begin
        w_bad = 1'b1;
      end
    endcase
  end

  assign o_err   = w_bad;
  assign o_instr = w_bad ? 32'h0 : w_raw;

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts one field-level request, encodes it in a
// dedicated cycle, then holds the word until the consumer takes it.
// Tracks the output word address and good/rejected request counts.
module instr_encoder
  import instr_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        out_err,
  output logic [31:0] out_addr,
  output logic [15:0] word_cnt,
  output logic [7:0]  err_cnt
);

  state_e      r_state;
  state_e      w_next;
  req_t        r_req;
  logic [31:0] r_instr;
  logic        r_err;
  logic [31:0] r_addr;
  logic [15:0] r_wcnt;
  logic [7:0]  r_ecnt;
  logic [31:0] w_instr;
  logic        w_err;
  logic        w_in_hs;
  logic        w_out_hs;

  assign w_in_hs  = in_valid && in_ready;
  assign w_out_hs = out_valid && out_ready;

  instr_pack u_pack (
    .i_req   (r_req),
    .o_instr (w_instr),
    .o_err   (w_err)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: capture -> encode -> hold until taken
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_in_hs)  w_next = ST_ENC;
      ST_ENC:                w_next = ST_OUT;
      ST_OUT:  if (w_out_hs) w_next = ST_IDLE;
      default:               w_next = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_OUT);
  end

  // Request capture; data only, so no reset needed
  always_ff @(posedge clk) begin
    if (w_in_hs) begin
      r_req.fmt    <= fmt_e'(fmt);
      r_req.opcode <= opcode;
      r_req.rd     <= rd;
      r_req.rs1    <= rs1;
      r_req.rs2    <= rs2;
      r_req.funct3 <= funct3;
      r_req.funct7 <= funct7;
      r_req.imm    <= imm;
    end
  end

  // Result register loaded during the encode cycle, stable through OUT
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instr <= 32'h0;
      r_err   <= 1'b0;
    end else if (r_state == ST_ENC) begin
      r_instr <= w_instr;
      r_err   <= w_err;
    end
  end

  // Address and counters advance only on an output handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr <= 32'h0;
      r_wcnt <= 16'h0;
      r_ecnt <= 8'h0;
    end else if (w_out_hs) begin
      if (r_err) begin
        if (r_ecnt != 8'hFF) r_ecnt <= r_ecnt + 8'd1;
      end else begin
        r_addr <= r_addr + 32'd4;
        if (r_wcnt != 16'hFFFF) r_wcnt <= r_wcnt + 16'd1;
      end
    end
  end

  assign instr    = r_instr;
  assign out_err  = r_err;
  assign out_addr = r_addr;
  assign word_cnt = r_wcnt;
  assign err_cnt  = r_ecnt;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed plus randomized bench for instr_encoder with an arithmetic
// reference model of the instruction formats and counter behaviour.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        out_err;
  logic [31:0] out_addr;
  logic [15:0] word_cnt;
  logic [7:0]  err_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  longint unsigned m_addr;
  int              m_wcnt;
  int              m_ecnt;
  logic [31:0]     last_instr;
  logic            last_err;

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .instr(instr), .out_err(out_err),
    .out_addr(out_addr), .word_cnt(word_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic longint bits(longint v, int hi, int lo);
    return (v >> lo) & ((64'sd1 << (hi - lo + 1)) - 1);
  endfunction

  // Reference encoding: {err, word} from the format rules
  function automatic logic [32:0] model(longint f, longint op, longint d, longint s1,
                                        longint s2, longint f3, longint f7, longint v);
    bit     e = 0;
    longint w = 0;
    case (f)
      0: w = op | d << 7 | f3 << 12 | s1 << 15 | s2 << 20 | f7 << 25;
      1: begin
        e = (v < -2048) || (v > 2047);
        w = op | d << 7 | f3 << 12 | s1 << 15 | bits(v, 11, 0) << 20;
      end
      2: begin
        e = (v < 0) || (v > 31);
        w = op | d << 7 | f3 << 12 | s1 << 15 | bits(v, 4, 0) << 20 | f7 << 25;
      end
      3: begin
        e = (v < -2048) || (v > 2047);
        w = op | bits(v, 4, 0) << 7 | f3 << 12 | s1 << 15 | s2 << 20 | bits(v, 11, 5) << 25;
      end
      4: begin
        e = (v < -4096) || (v > 4094) || ((v & 1) != 0);
        w = op | bits(v, 11, 11) << 7 | bits(v, 4, 1) << 8 | f3 << 12 | s1 << 15 | s2 << 20
            | bits(v, 10, 5) << 25 | bits(v, 12, 12) << 31;
      end
      5: begin
        e = bits(v, 11, 0) != 0;
        w = op | d << 7 | (bits(v, 31, 12) << 12);
      end
      6: begin
        e = (v < -1048576) || (v > 1048574) || ((v & 1) != 0);
        w = op | d << 7 | bits(v, 19, 12) << 12 | bits(v, 11, 11) << 20
            | bits(v, 10, 1) << 21 | bits(v, 20, 20) << 31;
      end
      default: e = 1;
    endcase
    if (e) w = 0;
    return {e, w[31:0]};
  endfunction

  // One full request: capture, latency, optional stall, handshake, counters
  task automatic do_req(input int f, input int op, input int d, input int s1, input int s2,
                        input int f3, input int f7, input int v, input int hold);
    logic [32:0] exp;
    int          lat;
    exp    = model(f, op, d, s1, s2, f3, f7, v);
    fmt    = f[2:0];   opcode = op[6:0]; rd = d[4:0]; rs1 = s1[4:0]; rs2 = s2[4:0];
    funct3 = f3[2:0];  funct7 = f7[6:0]; imm = v;
    in_valid = 1'b1;
    chk("ready_idle", {31'd0, in_ready}, 32'd1);
    tick();
    chk("ready_enc", {31'd0, in_ready}, 32'd0);
    chk("valid_enc", {31'd0, out_valid}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 8) begin
      in_valid = 1'b1;
      fmt = 3'($urandom); imm = $urandom; rd = 5'($urandom);
      tick();
      lat++;
    end
    chk("latency", lat, 32'd1);
    chk("instr", instr, exp[31:0]);
    chk("err", {31'd0, out_err}, {31'd0, exp[32]});
    last_instr = instr;
    last_err   = out_err;
    for (int i = 0; i < hold; i++) begin
      fmt = 3'($urandom); imm = $urandom; opcode = 7'($urandom);
      tick();
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_instr", instr, exp[31:0]);
      chk("hold_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    if (exp[32]) begin
      if (m_ecnt != 255) m_ecnt++;
    end else begin
      m_addr = (m_addr + 4) & 64'hFFFF_FFFF;
      if (m_wcnt != 65535) m_wcnt++;
    end
    chk("post_valid", {31'd0, out_valid}, 32'd0);
    chk("post_ready", {31'd0, in_ready}, 32'd1);
    chk("addr", out_addr, m_addr[31:0]);
    chk("word_cnt", {16'd0, word_cnt}, m_wcnt);
    chk("err_cnt", {24'd0, err_cnt}, m_ecnt);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_err"}, {31'd0, out_err}, 32'd0);
    chk({tag, "_addr"}, out_addr, 32'd0);
    chk({tag, "_wcnt"}, {16'd0, word_cnt}, 32'd0);
    chk({tag, "_ecnt"}, {24'd0, err_cnt}, 32'd0);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  int edges[18] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096,
                    -1048577, -1048576, 1048574, 1048575, 1048576, 0, 31, 32, -1};

  initial begin
    int v, sel, hold;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    m_addr = 0; m_wcnt = 0; m_ecnt = 0;
    tick(); tick();
    check_reset_state("rst_in");
    rst_n = 1'b1;
    tick();
    check_reset_state("rst_out");

    do_req(1, 'h13, 1, 0, 0, 0, 0, 5, 0);
    chk("i_addi_word", last_instr, 32'h00500093);
    chk("i_addi_addr", out_addr, 32'd4);

    do_req(4, 'h63, 0, 0, 0, 0, 0, -4, 0);
    chk("b_neg4_word", last_instr, 32'hFE000EE3);
    do_req(4, 'h63, 0, 0, 0, 0, 0, 3, 0);
    chk("b_odd_err", {31'd0, last_err}, 32'd1);
    chk("b_odd_word", last_instr, 32'd0);
    chk("b_odd_ecnt", {24'd0, err_cnt}, 32'd1);

    do_req(6, 'h6F, 1, 0, 0, 0, 0, 2048, 0);
    chk("j_word", last_instr, 32'h001000EF);
    do_req(5, 'h37, 5, 0, 0, 0, 0, 'h12345000, 0);
    chk("u_word", last_instr, 32'h123452B7);

    do_req(1, 'h13, 1, 0, 0, 0, 0, 2048, 0);
    chk("i_2048_err", {31'd0, last_err}, 32'd1);
    do_req(7, 'h13, 1, 0, 0, 0, 0, 0, 0);
    chk("fmt7_err", {31'd0, last_err}, 32'd1);
    chk("fmt7_addr", out_addr, 32'd16);
    chk("fmt7_wcnt", {16'd0, word_cnt}, 32'd4);

    do_req(0, 'h33, 3, 4, 5, 0, 'h20, 0, 10);

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0: v = $urandom_range(0, 80) - 40;
        1: v = edges[$urandom_range(0, 17)];
        2: v = $urandom;
        3: v = $urandom & 32'hFFFF_F000;
        default: v = edges[$urandom_range(0, 17)] + $urandom_range(0, 2) - 1;
      endcase
      hold = $urandom_range(0, 2);
      do_req($urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 7),
             $urandom_range(0, 127), v, hold);
    end

    // Saturate the rejected-request counter
    for (int n = 0; n < 260; n++) begin
      fmt = 3'd7; in_valid = 1'b1;
      tick(); in_valid = 1'b0;
      tick();
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      if (m_ecnt != 255) m_ecnt++;
    end
    chk("ecnt_sat", {24'd0, err_cnt}, 32'd255);
    chk("ecnt_sat_addr", out_addr, m_addr[31:0]);

    // Reset while a word is waiting in OUT
    fmt = 3'd1; opcode = 7'h13; rd = 5'd2; imm = 32'd7; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    tick(); tick();
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_state("rst_mid");
    tick();
    check_reset_state("rst_mid2");
    m_addr = 0; m_wcnt = 0; m_ecnt = 0;
    do_req(3, 'h23, 0, 2, 3, 2, 0, -2048, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all logic rising-edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: in_valid  in  1  request valid; in_ready  out  1  request accepted when both high.
REQ-004 SHALL have ports: fmt  in  3  format; opcode  in  7; rd, rs1, rs2  in  5 each; funct3  in  3; funct7  in  7; imm  in  32  signed immediate value (byte offset for B/J).
REQ-005 SHALL have ports: out_valid  out  1; out_ready  in  1; instr  out  32  encoded word; out_err  out  1  immediate not representable or fmt reserved.
REQ-006 SHALL have ports: out_addr  out  32  word address of current output; word_cnt  out  16  good words emitted; err_cnt  out  8  rejected requests.

Function
REQ-007 SHALL use fmt codes: R=0, I=1, ISH=2, S=3, B=4, U=5, J=6; 7 reserved and always flagged as error.
REQ-008 SHALL implement FSM IDLE -> ENC -> OUT -> IDLE; in_ready=1 only in IDLE; in_valid&&in_ready captures all fields and moves to ENC.
REQ-009 SHALL, in ENC, do the range check and pack into the instr/out_err registers in one cycle, then go to OUT.
REQ-010 SHALL hold out_valid=1 in OUT with instr/out_err stable until out_valid&&out_ready, then return to IDLE; latency is capture edge N to out_valid at N+2; max throughput is one word per 3 cycles.
REQ-011 SHALL pack as the inverse of the core immediate decode: I/ISH imm->[31:20]; S imm[11:5]->[31:25], imm[4:0]->[11:7]; B imm[12|10:5|4:1|11]->[31|30:25|11:8|7]; U imm[31:12]->[31:12]; J imm[20|10:1|11|19:12]->[31|30:21|20|19:12].
REQ-012 SHALL take opcode->[6:0], rd->[11:7], funct3->[14:12], rs1->[19:15], rs2->[24:20] where the format has them; R and ISH take funct7->[31:25]; R ignores imm.
REQ-013 SHALL flag out_err when the immediate is not representable:
- I/S: outside -2048..2047.
- B: outside -4096..4094, or imm[0]=1.
- J: outside -1048576..1048574, or imm[0]=1.
- U: imm[11:0]!=0.
- ISH: imm outside 0..31.
REQ-014 SHALL force instr=32'h0 when out_err=1.
REQ-015 SHALL, on an output handshake with out_err=0, increment out_addr by 4 (wrapping modulo 2^32) and word_cnt by 1 (saturating at 16'hFFFF).
REQ-016 SHALL, on an output handshake with out_err=1, increment err_cnt (saturating at 8'hFF) and leave out_addr and word_cnt unchanged.
REQ-017 SHALL ignore in_valid outside IDLE; the upstream source holds the request until accepted.

Reset
REQ-018 SHALL, at a rising clk edge with rst_n=0, return to IDLE from any state, including mid-OUT.
REQ-019 SHALL drive these values during reset and after release: out_valid=0, instr=0, out_err=0, out_addr=0, word_cnt=0, err_cnt=0, in_ready=1.

Structure
REQ-020 SHALL take the fmt enum, FSM state enum and immediate range limits from the shared package instr_pkg, which is also used by the core decode.
REQ-021 SHALL place the pure-combinational range check plus pack in one sub-module instr_pack; the top level holds the FSM, registers and counters.

Verification
REQ-022 Bench SHALL cover: fmt=I, opcode=0x13, rd=1, rs1=0, funct3=0, imm=5 -> instr=0x00500093, out_err=0, out_addr then 4.
REQ-023 Bench SHALL cover: fmt=B, opcode=0x63, rs1=0, rs2=0, funct3=0, imm=-4 -> instr=0xFE000EE3; same request with imm=3 -> out_err=1, instr=0, err_cnt=1.
REQ-024 Bench SHALL cover: fmt=J, opcode=0x6F, rd=1, imm=2048 -> 0x001000EF; fmt=U, opcode=0x37, rd=5, imm=0x12345000 -> 0x123452B7.
REQ-025 Bench SHALL cover: fmt=I with imm=2048, and fmt=7 -> out_err=1 for both; word_cnt and out_addr unchanged.
REQ-026 Bench SHALL cover: out_ready held low 10 cycles -> out_valid and instr stable, in_ready=0 throughout; out_ready high -> one handshake, then IDLE.
REQ-027 Bench SHALL cover: rst_n low for one edge while in OUT -> next cycle out_valid=0, all counters 0, in_ready=1.
